// File: rtl/prince_iter_ctrl.sv
// Iterative PRINCE sequencer: one external prince_core pass per clock, 12 rounds per block.
// Optional decrypt support is enabled by defining PRINCE_DECRYPT_EN.

module prince_sms (
    input  logic [63:0] x,
    output logic [63:0] y
);
    localparam logic [3:0] SB  [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    localparam logic [3:0] SBI [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    // Bit/nibble indices below are MSB-first: position 0 is the most significant.
    function automatic logic [15:0] mhat(input logic [15:0] d, input int unsigned h);
        logic [15:0] r;
        r = '0;
        for (int unsigned row = 0; row < 4; row++)
            for (int unsigned a = 0; a < 4; a++)
                for (int unsigned c = 0; c < 4; c++)
                    if (((row + c + h) % 4) != a)
                        r[15 - (4*row + a)] = r[15 - (4*row + a)] ^ d[15 - (4*c + a)];
        return r;
    endfunction

    logic [63:0] s_out, m_out;

    always_comb begin
        s_out = '0;
        for (int unsigned i = 0; i < 16; i++)
            s_out[4*i +: 4] = SB[x[4*i +: 4]];
        m_out = {mhat(s_out[63:48], 0), mhat(s_out[47:32], 1),
                 mhat(s_out[31:16], 1), mhat(s_out[15:0], 0)};
        y = '0;
        for (int unsigned i = 0; i < 16; i++)
            y[4*i +: 4] = SBI[m_out[4*i +: 4]];
    end
endmodule

module prince_iter_ctrl #(
    parameter logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  plain,
    input  logic [127:0] key,
`ifdef PRINCE_DECRYPT_EN
    input  logic         decrypt,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  cipher,
    output logic         busy,
    output logic [63:0]  core_data_in,
    output logic [63:0]  core_data_in0,
    output logic [63:0]  core_key,
    output logic         core_ctr,
    output logic [63:0]  core_rc,
    input  logic [63:0]  core_data_out,
    input  logic [63:0]  core_data_out0
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [63:0] st_q, st_d, cipher_q, cipher_d, plain_q, plain_d;
    logic [63:0] k0_q, k0_d, k0p_q, k0p_d, k1_q, k1_d;
    logic [63:0] kw_in, kw_out, k1_eff, sms_out;
    logic        accept;

    function automatic logic [63:0] rc_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    rc_rom = 64'h0000000000000000;
            4'd1:    rc_rom = 64'h13198A2E03707344;
            4'd2:    rc_rom = 64'hA4093822299F31D0;
            4'd3:    rc_rom = 64'h082EFA98EC4E6C89;
            4'd4:    rc_rom = 64'h452821E638D01377;
            4'd5:    rc_rom = 64'hBE5466CF34E90C6C;
            4'd6:    rc_rom = 64'h7EF84F78FD955CB1;
            4'd7:    rc_rom = 64'h85840851F1AC43AA;
            4'd8:    rc_rom = 64'hC882D32F25323C54;
            4'd9:    rc_rom = 64'h64A51195E0E3610D;
            4'd10:   rc_rom = 64'hD3B5A399CA0C2399;
            default: rc_rom = ALPHA;
        endcase
    endfunction

    assign accept    = in_valid && (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign cipher    = cipher_q;

`ifdef PRINCE_DECRYPT_EN
    logic dec_q, dec_d;
    assign dec_d = accept ? decrypt : dec_q;
    always_ff @(posedge clk) begin
        if (!rst_n) dec_q <= 1'b0;
        else        dec_q <= dec_d;
    end
    // Alpha-reflection: decryption swaps the whitening keys and tweaks k1, schedule unchanged.
    assign kw_in  = dec_q ? k0p_q : k0_q;
    assign kw_out = dec_q ? k0_q  : k0p_q;
    assign k1_eff = dec_q ? (k1_q ^ ALPHA) : k1_q;
`else
    assign kw_in  = k0_q;
    assign kw_out = k0p_q;
    assign k1_eff = k1_q;
`endif

    prince_sms u_sms (
        .x (st_q),
        .y (sms_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rnd_q    <= '0;
            st_q     <= '0;
            cipher_q <= '0;
            plain_q  <= '0;
            k0_q     <= '0;
            k0p_q    <= '0;
            k1_q     <= '0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            st_q     <= st_d;
            cipher_q <= cipher_d;
            plain_q  <= plain_d;
            k0_q     <= k0_d;
            k0p_q    <= k0p_d;
            k1_q     <= k1_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rnd_d         = rnd_q;
        st_d          = st_q;
        cipher_d      = cipher_q;
        plain_d       = plain_q;
        k0_d          = k0_q;
        k0p_d         = k0p_q;
        k1_d          = k1_q;
        core_ctr      = 1'b1;
        core_rc       = '0;
        core_key      = '0;
        core_data_in  = '0;
        core_data_in0 = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    rnd_d   = '0;
                    plain_d = plain;
                    k0_d    = key[127:64];
                    k0p_d   = {key[64], key[127:65]} ^ {63'd0, key[127]};
                    k1_d    = key[63:0];
                end
            end
            RUN: begin
                core_key = k1_eff;
                core_rc  = rc_rom(rnd_q);
                if (rnd_q == 4'd0) begin
                    core_data_in0 = plain_q ^ kw_in;
                    st_d          = core_data_out;
                end else if (rnd_q <= 4'd5) begin
                    core_ctr     = 1'b0;
                    core_data_in = st_q;
                    st_d         = core_data_out;
                end else if (rnd_q == 4'd6) begin
                    core_data_in0 = sms_out;
                    st_d          = core_data_out0;
                end else if (rnd_q != 4'd11) begin
                    core_data_in0 = st_q;
                    st_d          = core_data_out0;
                end else begin
                    core_data_in0 = st_q;
                end
                if (rnd_q == 4'd11) begin
                    cipher_d = core_data_out ^ kw_out;
                    state_d  = DONE;
                    rnd_d    = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_prince_iter_ctrl.sv
// Directed bench for prince_iter_ctrl with a behavioural prince_core attached to the core ports.
`timescale 1ns/1ps

module tb_prince_iter_ctrl;
    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy, core_ctr;
    logic [63:0]  plain, cipher, core_data_in, core_data_in0, core_key, core_rc;
    logic [63:0]  core_data_out, core_data_out0, core_pre;
    logic [127:0] key;
`ifdef PRINCE_DECRYPT_EN
    logic         decrypt;
`endif
    int tests = 0;
    int fails = 0;

    localparam logic [63:0] SBOX = 64'hBF32AC916780E5D4;
    localparam logic [63:0] SINV = 64'hB732FD89A6405EC1;
    localparam int SR_P [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    localparam logic [63:0]  V_PT  [5] = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                                           64'h0123456789ABCDEF, 64'h0};
    localparam logic [127:0] V_KEY [5] = '{128'h0, 128'h0,
                                           {64'hFFFFFFFFFFFFFFFF, 64'h0},
                                           {64'h0, 64'hFEDCBA9876543210},
                                           {64'h0, 64'hFFFFFFFFFFFFFFFF}};
    localparam logic [63:0]  V_CT  [5] = '{64'h818665AA0D02DFDA, 64'h604AE6CA03C20ADA,
                                           64'h9FB51935FC3DF524, 64'hAE25AD3CA8FA9CCF,
                                           64'h78A54CBE737BB7EF};

    prince_iter_ctrl #(.ALPHA(64'hC0AC29B7C97C50DD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .plain          (plain),
        .key            (key),
`ifdef PRINCE_DECRYPT_EN
        .decrypt        (decrypt),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .cipher         (cipher),
        .busy           (busy),
        .core_data_in   (core_data_in),
        .core_data_in0  (core_data_in0),
        .core_key       (core_key),
        .core_ctr       (core_ctr),
        .core_rc        (core_rc),
        .core_data_out  (core_data_out),
        .core_data_out0 (core_data_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] tb_sub(input logic [63:0] x, input logic [63:0] tbl);
        logic [63:0] y;
        int v;
        for (int i = 0; i < 16; i++) begin
            v = int'(x[4*i +: 4]);
            y[4*i +: 4] = tbl[60-4*v +: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] tb_mp(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  m;
        int h, k;
        y = '0;
        for (int ch = 0; ch < 4; ch++) begin
            h = (ch == 1 || ch == 2) ? 1 : 0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    k = (r + c + h) % 4;
                    m = 4'hF ^ (4'h8 >> k);
                    y[63-16*ch-4*r -: 4] = y[63-16*ch-4*r -: 4] ^ (x[63-16*ch-4*c -: 4] & m);
                end
        end
        return y;
    endfunction

    function automatic logic [63:0] tb_sr(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int i = 0; i < 16; i++)
            if (inv) y[60-4*SR_P[i] +: 4] = x[60-4*i +: 4];
            else     y[60-4*i +: 4]       = x[60-4*SR_P[i] +: 4];
        return y;
    endfunction

    // Forward round is S, M', SR then key/RC add; inverse round undoes it after the add.
    always_comb begin
        core_pre       = core_ctr ? core_data_in0 : tb_sr(tb_mp(tb_sub(core_data_in, SBOX)), 1'b0);
        core_data_out  = core_pre ^ core_key ^ core_rc;
        core_data_out0 = tb_sub(tb_mp(tb_sr(core_pre ^ core_key ^ core_rc, 1'b1)), SINV);
    end

    task automatic do_block(input logic [63:0] pt, input logic [127:0] k,
                            output logic [63:0] ct, output int lat);
        lat = -1;
        plain = pt; key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        ct = cipher;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (cipher !== 64'h0) begin fails++; $display("FAIL reset_cipher got %h want 0", cipher); end
        tests++; if (core_ctr !== 1'b1) begin fails++; $display("FAIL idle_core_ctr got %b want 1", core_ctr); end
        tests++; if (core_key !== 64'h0 || core_rc !== 64'h0) begin
            fails++; $display("FAIL idle_core_key_rc got %h/%h want 0/0", core_key, core_rc); end
        tests++; if (core_data_in !== 64'h0 || core_data_in0 !== 64'h0) begin
            fails++; $display("FAIL idle_core_data got %h/%h want 0/0", core_data_in, core_data_in0); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [63:0] ct;
        int lat;
        for (int v = 0; v < 5; v++) begin
            do_block(V_PT[v], V_KEY[v], ct, lat);
            tests++; if (lat != 12) begin fails++; $display("FAIL vec%0d_latency got %0d want 12", v, lat); end
            tests++; if (ct !== V_CT[v]) begin fails++; $display("FAIL vec%0d_cipher got %h want %h", v, ct, V_CT[v]); end
            handoff();
            tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++; $display("FAIL vec%0d_handoff got valid=%b ready=%b want 0/1", v, out_valid, in_ready); end
        end
    endtask

    task automatic test_hold_and_ignore();
        int lat = -1;
        plain = '0; key = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            if (n == 4) begin
                tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    fails++; $display("FAIL run_flags got busy=%b ready=%b want 1/0", busy, in_ready); end
                plain = '1; key = '1; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) lat = n;
        end
        tests++; if (lat != 12) begin fails++; $display("FAIL hold_latency got %0d want 12", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 1);
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || cipher !== 64'h818665AA0D02DFDA || in_ready !== 1'b0) begin
                fails++; $display("FAIL hold_cycle%0d got valid=%b ct=%h ready=%b want 1/818665aa0d02dfda/0",
                                  c, out_valid, cipher, in_ready); end
        end
        in_valid = 1'b0; plain = '0; key = '0;
        handoff();
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL hold_handoff got valid=%b busy=%b want 0/0", out_valid, busy); end
        tests++; if (cipher !== 64'h818665AA0D02DFDA) begin
            fails++; $display("FAIL hold_cipher_kept got %h want 818665aa0d02dfda", cipher); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL no_queued_accept got busy=%b ready=%b want 0/1", busy, in_ready); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] ct;
        int lat;
        plain = V_PT[3]; key = V_KEY[3]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrun_reset_flags got ready=%b valid=%b busy=%b want 1/0/0",
                              in_ready, out_valid, busy); end
        tests++; if (cipher !== 64'h0) begin fails++; $display("FAIL midrun_reset_cipher got %h want 0", cipher); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_block(64'h0, 128'h0, ct, lat);
        tests++; if (lat != 12) begin fails++; $display("FAIL after_reset_latency got %0d want 12", lat); end
        tests++; if (ct !== 64'h818665AA0D02DFDA) begin
            fails++; $display("FAIL after_reset_cipher got %h want 818665aa0d02dfda", ct); end
        handoff();
    endtask

`ifdef PRINCE_DECRYPT_EN
    task automatic test_decrypt();
        logic [63:0] ct;
        int lat;
        decrypt = 1'b1;
        do_block(64'h818665AA0D02DFDA, 128'h0, ct, lat);
        decrypt = 1'b0;
        tests++; if (ct !== 64'h0) begin fails++; $display("FAIL dec_zero got %h want 0", ct); end
        handoff();
        decrypt = 1'b1;
        do_block(64'hAE25AD3CA8FA9CCF, {64'h0, 64'hFEDCBA9876543210}, ct, lat);
        decrypt = 1'b0;
        tests++; if (ct !== 64'h0123456789ABCDEF) begin
            fails++; $display("FAIL dec_vec3 got %h want 0123456789abcdef", ct); end
        handoff();
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plain = '0; key = '0;
`ifdef PRINCE_DECRYPT_EN
        decrypt = 1'b0;
`endif
        test_reset();
        test_vectors();
        test_hold_and_ignore();
        test_reset_mid_run();
`ifdef PRINCE_DECRYPT_EN
        test_decrypt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
